// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array read-side blocks.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic int elem_width(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/drain_elem_select.sv
// Snapshot register for one array pass plus the row-major element selector
// that presents element k on the stream outputs.
module drain_elem_select
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       capture,
  input  logic                                       active,
  input  logic [elem_width(DATA_WIDTH)*SIZE*SIZE-1:0] result_in,
  input  logic [idx_width(SIZE*SIZE)-1:0]            k,
  output logic [elem_width(DATA_WIDTH)-1:0]          out_data,
  output logic [idx_width(SIZE)-1:0]                 out_row,
  output logic [idx_width(SIZE)-1:0]                 out_col,
  output logic                                       out_last
);

  localparam int EW = elem_width(DATA_WIDTH);
  localparam int N  = SIZE * SIZE;
  localparam int IW = idx_width(SIZE);
  localparam int KW = idx_width(N);

  logic [EW-1:0] snap_r [N];

  // Snapshot the whole bus once settling completes; later bus changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) snap_r[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N; i++) snap_r[i] <= result_in[i*EW +: EW];
    end
  end

  // Row-major decode of k into (row, col) and the selected element
  always_comb begin
    out_data = snap_r[k];
    out_row  = IW'(k / KW'(SIZE));
    out_col  = IW'(k % KW'(SIZE));
    out_last = active && (k == KW'(N - 1));
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains one settled systolic-array result pass as a valid/ready stream of
// SIZE*SIZE signed elements in row-major order.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SIZE          = 4,
  parameter int SETTLE_CYCLES = SIZE
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [elem_width(DATA_WIDTH)*SIZE*SIZE-1:0] result_in,
  output logic                                       busy,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [elem_width(DATA_WIDTH)-1:0]          out_data,
  output logic [idx_width(SIZE)-1:0]                 out_row,
  output logic [idx_width(SIZE)-1:0]                 out_col,
  output logic                                       out_last,
  output logic                                       done
);

  localparam int N  = SIZE * SIZE;
  localparam int KW = idx_width(N);
  localparam int CW = idx_width(SETTLE_CYCLES);

  state_t          state_r, state_nx;
  logic [CW-1:0]   cnt_r, cnt_nx;
  logic [KW-1:0]   k_r, k_nx;
  logic            capture_s, done_nx;
  logic            busy_r, valid_r, done_r;

  // State, counters and status flags; status is registered from next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      k_r     <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      k_r     <= k_nx;
      busy_r  <= (state_nx != IDLE);
      valid_r <= (state_nx == STREAM);
      done_r  <= done_nx;
    end
  end

  // Next-state logic; start is only honoured in IDLE, never queued
  always_comb begin
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    k_nx      = k_r;
    capture_s = 1'b0;
    done_nx   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_r == CW'(SETTLE_CYCLES - 1)) begin
          capture_s = 1'b1;
          k_nx      = '0;
          state_nx  = STREAM;
        end else begin
          cnt_nx = cnt_r + CW'(1);
        end
      end
      STREAM: begin
        if (valid_r && out_ready) begin
          if (k_r == KW'(N - 1)) begin
            k_nx     = '0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            k_nx = k_r + KW'(1);
          end
        end else begin
          k_nx = k_r;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        k_nx     = '0;
      end
    endcase
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign done      = done_r;

  drain_elem_select #(
    .DATA_WIDTH(DATA_WIDTH),
    .SIZE      (SIZE)
  ) u_sel (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture_s),
    .active   (valid_r),
    .result_in(result_in),
    .k        (k_r),
    .out_data (out_data),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain with DATA_WIDTH=8, SIZE=4, SETTLE_CYCLES=4.
module tb_systolic_result_drain;

  localparam int EW = 16;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [EW*N-1:0] result_in = '0;
  logic          busy, out_valid, out_last, done;
  logic [EW-1:0] out_data;
  logic [1:0]    out_row, out_col;
  logic [EW-1:0] exp_mem [N];
  int            n_assert = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(
    .DATA_WIDTH(8),
    .SIZE(4),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .result_in(result_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_bus;
    for (int i = 0; i < N; i++) result_in[i*EW +: EW] = exp_mem[i];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_row"}, out_row, 0);
    chk({tag, "_col"}, out_col, 0);
  endtask

  // Caller drives start=1 in cycle 0; the pass runs until abort_k beats are accepted.
  task automatic run_pass(input bit bp, input bit poke, input int abort_k);
    int cyc = 1;
    int k = 0;
    tick;
    start = 1'b0;
    while (k < abort_k && cyc < 80) begin
      out_ready = bp ? (cyc % 2 == 0) : 1'b1;
      if (poke && cyc == 5) begin
        result_in = {N{16'h7FFF}};
        start = 1'b1;
      end
      if (poke && cyc == 6) start = 1'b0;
      if (poke && cyc == 20) start = 1'b1;
      chk("busy", busy, 1);
      if (cyc < 5) begin
        chk("valid_settle", out_valid, 0);
      end else begin
        chk("valid", out_valid, 1);
        chk("data", out_data, exp_mem[k]);
        chk("row", out_row, k / 4);
        chk("col", out_col, k % 4);
        chk("last", out_last, (k == N - 1));
        if (out_ready) begin
          if (k == N - 1) chk("last_cycle", cyc, bp ? 36 : 20);
          k++;
        end
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    chk("handshakes", k, abort_k);
    if (abort_k == N) begin
      chk("done_cycle", done, 1);
      chk("done_valid", out_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_last", out_last, 0);
    end
  endtask

  initial begin
    #1;
    chk_zero("reset");
    #11;
    rst = 1'b1;
    tick;

    // Basic pass: element k = 3k
    for (int i = 0; i < N; i++) exp_mem[i] = 16'(3 * i);
    load_bus;
    start = 1'b1;
    run_pass(1'b0, 1'b0, N);
    tick;
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);

    // Backpressure with alternating ready
    for (int i = 0; i < N; i++) exp_mem[i] = 16'(16'h1000 + i);
    load_bus;
    start = 1'b1;
    run_pass(1'b1, 1'b0, N);
    tick;
    chk("bp_done_once", done, 0);

    // Snapshot holds against bus changes; starts during STREAM ignored
    for (int i = 0; i < N; i++) exp_mem[i] = 16'(7 * i);
    load_bus;
    start = 1'b1;
    run_pass(1'b0, 1'b1, N);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("no_requeue_busy", busy, 0);
      chk("no_requeue_valid", out_valid, 0);
    end
    for (int i = 0; i < N; i++) exp_mem[i] = 16'h7FFF;
    load_bus;
    start = 1'b1;
    run_pass(1'b0, 1'b0, N);

    // Sign pass, started in the done cycle of the previous pass
    for (int i = 0; i < N; i++) exp_mem[i] = 16'(3 * i);
    exp_mem[5]  = 16'hFF38;
    exp_mem[15] = 16'h8000;
    load_bus;
    start = 1'b1;
    run_pass(1'b0, 1'b0, N);
    tick;
    chk("sign_done_once", done, 0);

    // Reset after the beat-7 handshake
    for (int i = 0; i < N; i++) exp_mem[i] = 16'(16'h0A00 + 11 * i);
    load_bus;
    start = 1'b1;
    run_pass(1'b0, 1'b0, 8);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_reset");
    tick;
    tick;
    #3;
    rst = 1'b1;
    tick;
    chk_zero("post_reset");
    for (int i = 0; i < N; i++) exp_mem[i] = 16'(13 * i + 5);
    load_bus;
    start = 1'b1;
    run_pass(1'b0, 1'b0, N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Captures the packed accumulator bus of the systolic array once a compute pass has settled, then streams the SIZE*SIZE results out one element per handshake over a valid/ready interface. It sits directly on the `result` output of the systolic array and is the read-side counterpart to the array's packed parallel output. It snapshots the bus, so the array may start its next pass while the drain is still streaming.

## Interface
- `DATA_WIDTH`, 8, operand width; each result element is 2*DATA_WIDTH bits, signed
- `SIZE`, 4, array dimension; SIZE*SIZE elements per pass
- `SETTLE_CYCLES`, SIZE, cycles from `start` to capture; minimum 1
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: request a drain pass; sampled only in IDLE
- `result_in` in 2*DATA_WIDTH*SIZE*SIZE: packed array results; element k = i*SIZE+j at bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH]
- `busy` out 1: high whenever state != IDLE
- `out_valid` out 1: element available
- `out_ready` in 1: consumer accepts the element
- `out_data` out 2*DATA_WIDTH: signed element, bit-exact slice of the snapshot
- `out_row` out max(1,$clog2(SIZE)): i of the current element
- `out_col` out max(1,$clog2(SIZE)): j of the current element
- `out_last` out 1: high with the element k = SIZE*SIZE-1
- `done` out 1: one-cycle pulse after the final handshake

## Operation
- States are IDLE, SETTLE and STREAM.
- **IDLE:** `start`=1 moves to SETTLE and clears the settle counter.
- **SETTLE:** the counter increments each cycle.
  - On the edge where the counter equals SETTLE_CYCLES-1, capture all of `result_in` into the snapshot register, set index k=0 and go to STREAM.
- **STREAM:** `out_valid`=1, and `out_data`/`out_row`/`out_col`/`out_last` reflect snapshot element k.
  - On `out_valid && out_ready`, k increments.
  - On the handshake at k = SIZE*SIZE-1, go to IDLE, pulse `done` for the next cycle and clear `out_valid`.
- Traversal is row-major: (0,0), (0,1) … (SIZE-1,SIZE-1).
- `start` outside IDLE is ignored, with no queuing; this includes the cycle of the final handshake.
- Changes on `result_in` after capture have no effect on streamed data.
- No arithmetic is performed. Data passes through unmodified, sign preserved.

## Timing
- **Reset values:** state IDLE; `busy`, `out_valid`, `out_last` and `done` are 0; `out_data`, `out_row` and `out_col` are 0. Reset takes effect immediately (asynchronous), and the snapshot and counters clear.
- **Latency:** with `start` sampled at edge E0, `out_valid` rises after edge E(SETTLE_CYCLES). For SETTLE_CYCLES=4, a start in cycle 0 gives the first beat in cycle 5.
- **Throughput:** one element per cycle while `out_ready`=1. A pass takes SETTLE_CYCLES + SIZE*SIZE cycles at minimum.
- **Backpressure:** while `out_valid && !out_ready`, all out_* signals hold stable. `out_valid` never drops before a handshake.
- **`done`:** asserted exactly one cycle, in the first IDLE cycle. A `start` in that same cycle is accepted.
- **Reset mid-pass:** the stream aborts, there is no `done`, and no partial state survives. The next `start` restarts at element 0.

## Structure
- **Shared package `systolic_pkg`:**
  - state enum (IDLE, SETTLE, STREAM)
  - element-width constant expression (2*DATA_WIDTH)
  - index width function
- **Natural sub-module `drain_elem_select`:** the snapshot register plus the row-major element mux driving `out_data`/`out_row`/`out_col`/`out_last` from k.
- The FSM and counters stay in the top module.

## Test plan
All scenarios use DATA_WIDTH=8, SIZE=4, SETTLE_CYCLES=4.
- **Reset:** assert `rst`=0 mid-simulation → all outputs 0 the same cycle; `busy`=0.
- **Basic pass:** element k = 3k, `out_ready`=1, `start` pulse in cycle 0 → `out_valid` from cycle 5, 16 consecutive beats 0,3,…,45 with (row,col) counting (0,0)…(3,3), `out_last` only on beat 15, `done`=1 in cycle 21 only.
- **Backpressure:** `out_ready` alternating 0/1 → each element held until accepted, exactly 16 handshakes, no duplicates or drops, last beat in cycle 36.
- **Snapshot and ignored start:** drive `result_in` to all 16'h7FFF after capture and pulse `start` during STREAM → streamed values remain the captured set; a second pass occurs only on a later `start`.
- **Sign:** element 5 = 16'hFF38 (-200) and element 15 = 16'h8000 → streamed bit-exact.
- **Reset mid-stream:** reset after the beat-7 handshake → IDLE, no `done`; a new `start` streams from element 0 with a fresh capture.
